// File: rtl/div_issue_queue.sv
// div_issue_queue: in-order request FIFO that feeds a serial divider one operation at a time
// and holds each tagged result on a valid/ready output until it is consumed.
module div_issue_queue #(
  parameter int BW   = 32,
  parameter int DEPTH = 4,
  parameter int TAGW = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_signed,
  input  logic [BW-1:0]                in_num,
  input  logic [BW-1:0]                in_den,
  input  logic [TAGW-1:0]              in_tag,
  output logic                         o_div_wr,
  output logic                         o_div_signed,
  output logic [BW-1:0]                o_div_numerator,
  output logic [BW-1:0]                o_div_denominator,
  input  logic                         i_div_busy,
  input  logic                         i_div_valid,
  input  logic                         i_div_err,
  input  logic [BW-1:0]                i_div_quotient,
  input  logic [3:0]                   i_div_flags,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BW-1:0]                out_quotient,
  output logic [3:0]                   out_flags,
  output logic                         out_err,
  output logic [TAGW-1:0]              out_tag,
  output logic [$clog2(DEPTH+2)-1:0]   o_pending,
  output logic                         o_proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH+2);
  localparam int EW = 1 + 2*BW + TAGW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t          state, state_next;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [TAGW-1:0] tag_q;
  logic            push, issue, done;

  assign in_ready = (count != CW'(DEPTH)) && !i_reset;
  assign push     = in_valid && in_ready;
  assign issue    = (state == S_IDLE) && (count != '0) && !i_div_busy;
  assign done     = (state == S_HOLD) && out_ready;
  assign head     = mem[rd_ptr];

  always_comb begin
    state_next = state == S_IDLE ? (issue ? S_WAIT : S_IDLE)
               : state == S_WAIT ? (i_div_valid ? S_HOLD : S_WAIT)
               : (out_ready ? S_IDLE : S_HOLD);
    count_next = count + CW'(push) - CW'(issue);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {in_signed, in_num, in_den, in_tag};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      o_div_wr          <= 1'b0;
      o_div_signed      <= 1'b0;
      o_div_numerator   <= '0;
      o_div_denominator <= '0;
      tag_q             <= '0;
      out_valid         <= 1'b0;
      out_quotient      <= '0;
      out_flags         <= '0;
      out_err           <= 1'b0;
      out_tag           <= '0;
      o_pending         <= '0;
      o_proto_err       <= 1'b0;
    end else begin
      count     <= count_next;
      o_div_wr  <= issue;
      o_pending <= PW'(count_next) + PW'(state_next != S_IDLE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) begin
        rd_ptr            <= rd_ptr + 1'b1;
        o_div_signed      <= head[EW-1];
        o_div_numerator   <= head[EW-2 -: BW];
        o_div_denominator <= head[TAGW+BW-1 -: BW];
        tag_q             <= head[TAGW-1:0];
      end
      if (state == S_WAIT && i_div_valid) begin
        out_valid    <= 1'b1;
        out_quotient <= i_div_quotient;
        out_flags    <= i_div_flags;
        out_err      <= i_div_err;
        out_tag      <= tag_q;
      end
      if (done) out_valid <= 1'b0;
      if (i_div_valid && state != S_WAIT) o_proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_div_issue_queue.sv
// tb_div_issue_queue: randomized and directed checks of div_issue_queue against a queue-based
// transaction model, with a behavioural divider stub standing in for the serial divider.
module tb_div_issue_queue;
  localparam int BW = 32, DEPTH = 4, TAGW = 4, PW = $clog2(DEPTH+2);

  logic i_clk = 0, i_reset = 1;
  logic in_valid = 0, in_signed = 0, out_ready = 0;
  logic [BW-1:0] in_num = 0, in_den = 0;
  logic [TAGW-1:0] in_tag = 0;
  logic i_div_busy = 0, i_div_valid = 0, i_div_err = 0;
  logic [BW-1:0] i_div_quotient = 0;
  logic [3:0] i_div_flags = 0;
  logic in_ready, o_div_wr, o_div_signed, out_valid, out_err, o_proto_err;
  logic [BW-1:0] o_div_numerator, o_div_denominator, out_quotient;
  logic [3:0] out_flags;
  logic [TAGW-1:0] out_tag;
  logic [PW-1:0] o_pending;

  div_issue_queue #(.BW(BW), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
    .o_div_wr(o_div_wr), .o_div_signed(o_div_signed), .o_div_numerator(o_div_numerator),
    .o_div_denominator(o_div_denominator), .i_div_busy(i_div_busy), .i_div_valid(i_div_valid),
    .i_div_err(i_div_err), .i_div_quotient(i_div_quotient), .i_div_flags(i_div_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_flags(out_flags), .out_err(out_err), .out_tag(out_tag), .o_pending(o_pending),
    .o_proto_err(o_proto_err));

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: pending request queue, at most one op at the divider, at most one held result.
  typedef struct packed {logic s; logic [BW-1:0] n; logic [BW-1:0] d; logic [TAGW-1:0] t;} req_t;
  req_t mq[$];
  req_t cur, nr;
  logic infl = 0, held = 0, m_proto = 0, m_wr = 0, m_push = 0, m_iss = 0;
  logic [BW-1:0] m_q = 0;
  logic [3:0] m_f = 0;
  logic m_e = 0;
  logic [TAGW-1:0] m_t = 0;

  always @(posedge i_clk) begin
    if (i_reset) begin
      mq.delete();
      infl = 0; held = 0; m_proto = 0; m_wr = 0; m_push = 0;
      cur = '0;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_iss  = !infl && !held && (mq.size() > 0) && !i_div_busy;
      if (i_div_valid && !infl) m_proto = 1;
      if (held && out_ready) held = 0;
      if (infl && i_div_valid) begin
        held = 1; infl = 0;
        m_q = i_div_quotient; m_f = i_div_flags; m_e = i_div_err; m_t = cur.t;
      end
      m_wr = m_iss;
      if (m_iss) begin cur = mq.pop_front(); infl = 1; end
      if (m_push) begin
        nr.s = in_signed; nr.n = in_num; nr.d = in_den; nr.t = in_tag;
        mq.push_back(nr);
      end
    end
  end

  logic chk_en = 0;
  always @(negedge i_clk) if (chk_en) begin
    chk("in_ready", in_ready, (mq.size() < DEPTH) && !i_reset);
    chk("o_div_wr", o_div_wr, m_wr);
    chk("out_valid", out_valid, held);
    chk("o_pending", o_pending, mq.size() + (infl || held));
    chk("o_proto_err", o_proto_err, m_proto);
    if (infl) begin
      chk("o_div_signed", o_div_signed, cur.s);
      chk("o_div_numerator", o_div_numerator, cur.n);
      chk("o_div_denominator", o_div_denominator, cur.d);
    end
    if (held) begin
      chk("out_quotient", out_quotient, m_q);
      chk("out_flags", out_flags, m_f);
      chk("out_err", out_err, m_e);
      chk("out_tag", out_tag, m_t);
    end
  end

  // Divider stub: busy from the start pulse until a one-cycle valid after a chosen latency.
  logic st_act = 0, st_s = 0, busy_en = 0, force_spur = 0;
  logic [BW-1:0] st_n = 0, st_d = 0;
  int st_cnt = 0, lat_force = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
    i_div_quotient = $urandom;
    i_div_flags    = 4'($urandom);
    i_div_err      = 1'($urandom);
    if (i_reset) begin
      st_act = 0; i_div_valid = 0; i_div_busy = 0;
    end else if (m_wr) begin
      st_act = 1; i_div_valid = 0; i_div_busy = 1;
      st_cnt = lat_force != 0 ? lat_force : $urandom_range(1, 5);
      st_s = cur.s; st_n = cur.n; st_d = cur.d;
    end else if (st_act) begin
      st_cnt--;
      i_div_valid = (st_cnt == 0);
      if (st_cnt == 0) begin
        st_act = 0; i_div_busy = 0; i_div_err = (st_d == 0);
        if (st_d == 0) i_div_quotient = '1;
        else if (st_s && st_n == 32'h8000_0000 && st_d == '1) i_div_quotient = st_n;
        else if (st_s) i_div_quotient = $signed(st_n) / $signed(st_d);
        else i_div_quotient = st_n / st_d;
      end
    end else begin
      i_div_valid = force_spur;
      i_div_busy  = busy_en && ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic offer(input logic s, input logic [BW-1:0] n, input logic [BW-1:0] d, input logic [TAGW-1:0] t);
    in_valid = 1; in_signed = s; in_num = n; in_den = d; in_tag = t;
    step();
    in_valid = 0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!o_div_wr && n < 100) begin step(); n++; end
    chk("wait_div_wr", o_div_wr, 1);
  endtask

  int acc, seen;

  initial begin
    step(); step();
    i_reset = 0;
    chk_en = 1;
    out_ready = 1;

    // 100/7 unsigned, tag 3: start pulse exactly one cycle after acceptance
    offer(0, 100, 7, 3);
    chk("t1_wr_not_yet", o_div_wr, 0);
    step();
    chk("t1_wr", o_div_wr, 1);
    chk("t1_num", o_div_numerator, 100);
    chk("t1_den", o_div_denominator, 7);
    step();
    chk("t1_wr_one_cycle", o_div_wr, 0);
    wait_out();
    chk("t1_quot", out_quotient, 14);
    chk("t1_tag", out_tag, 3);
    chk("t1_err", out_err, 0);
    step(); step();
    chk("t1_pending", o_pending, 0);

    // signed -7/2, tag 5
    offer(1, 32'hFFFF_FFF9, 2, 5);
    wait_wr();
    chk("t2_signed", o_div_signed, 1);
    wait_out();
    chk("t2_quot", out_quotient, 32'hFFFF_FFFD);
    chk("t2_tag", out_tag, 5);
    step(); step();

    // backpressure: 6 offers, 5 fit (1 at the divider/held + 4 queued)
    out_ready = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_signed = 0; in_tag = TAGW'(acc);
      in_num = 100 + acc; in_den = BW'(acc + 1);
      acc += int'(in_valid && in_ready);
      step();
    end
    in_valid = 0;
    chk("bp_accepted", acc, 5);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 8; i++) step();
    chk("bp_pending", o_pending, 5);
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      wait_out();
      chk("bp_tag", out_tag, i);
      chk("bp_quot", out_quotient, (100 + i) / (i + 1));
      step();
    end

    // divide by zero, then a normal op
    offer(0, 10, 0, 1);
    wait_out();
    chk("dz_err", out_err, 1);
    chk("dz_quot", out_quotient, 32'hFFFF_FFFF);
    step();
    offer(0, 9, 3, 2);
    wait_out();
    chk("n_quot", out_quotient, 3);
    chk("n_err", out_err, 0);
    step(); step();

    // reset while waiting on the divider with two requests queued
    lat_force = 30;
    offer(0, 50, 5, 7);
    offer(0, 60, 5, 8);
    offer(0, 70, 5, 9);
    chk("rst_pending_before", o_pending, 3);
    i_reset = 1;
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    step();
    chk("rst_wr", o_div_wr, 0);
    chk("rst_signed", o_div_signed, 0);
    chk("rst_num", o_div_numerator, 0);
    chk("rst_den", o_div_denominator, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_quot", out_quotient, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_proto", o_proto_err, 0);
    i_reset = 0;
    #1;
    chk("rst_in_ready_high", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(); seen += int'(out_valid || o_div_wr); end
    chk("rst_no_ghost", seen, 0);
    lat_force = 0;

    // spurious divider valid while idle
    force_spur = 1;
    step();
    force_spur = 0;
    step();
    chk("spur_proto", o_proto_err, 1);
    chk("spur_out_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) step();
    chk("spur_sticky", o_proto_err, 1);
    i_reset = 1; step(); i_reset = 0;

    // randomized traffic with occasional resets and divider stalls
    busy_en = 1;
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_signed = 1'($urandom);
      in_num    = $urandom;
      in_den    = ($urandom_range(0, 9) == 0) ? 0 : ($urandom_range(0, 1) ? $urandom : BW'($urandom_range(1, 50)));
      in_tag    = TAGW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      i_reset   = ($urandom_range(0, 399) == 0);
      step();
    end
    i_reset = 0; in_valid = 0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
